// File: rtl/i2c_slave_mem.sv
// EEPROM-style I2C target: oversampled scl/sda, START/STOP detection, 1/2-byte
// memory addressing, auto-incrementing pointer, open-drain sda (0 or z only).
module i2c_slave_mem #(
  parameter logic [6:0] DEV_ADDR  = 7'b101_0001,
  parameter int         HIGH_ADDR = 0,
  parameter int         MEM_AW    = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              scl,
  inout  wire               sda,
  output logic              busy,
  output logic              wr_en,
  output logic [MEM_AW-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DEV    = 3'd1;
  localparam logic [2:0] S_ADDR_H = 3'd2;
  localparam logic [2:0] S_ADDR_L = 3'd3;
  localparam logic [2:0] S_WR     = 3'd4;
  localparam logic [2:0] S_RD     = 3'd5;
  localparam logic [2:0] S_RD_ACK = 3'd6;
  localparam logic [2:0] S_SKIP   = 3'd7;

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_prev_q, sda_prev_q;
  logic [2:0] arm_q;

  logic [7:0] mem_q [0:(1<<MEM_AW)-1];

  logic [2:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        rx_q, rx_d;
  logic [6:0]        tx_q, tx_d;
  logic [7:0]        addr_h_q, addr_h_d;
  logic [MEM_AW-1:0] ptr_q, ptr_d;
  logic              oe_q, oe_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              wr_en_q, wr_en_d;
  logic [MEM_AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;

  // Edges are suppressed until the sync/prev pipeline holds real bus values,
  // so a reset released mid-transfer cannot fabricate a START.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      arm_q      <= 3'b000;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl};
      sda_sync_q <= {sda_sync_q[0], sda};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
      arm_q      <= {arm_q[1:0], 1'b1};
    end
  end

  logic scl_s, sda_s, scl_rise, scl_fall, sda_rise, sda_fall, start_c, stop_c;
  logic [7:0] mem_rd;

  assign scl_s    = scl_sync_q[1];
  assign sda_s    = sda_sync_q[1];
  assign scl_rise = arm_q[2] &  scl_s & ~scl_prev_q;
  assign scl_fall = arm_q[2] & ~scl_s &  scl_prev_q;
  assign sda_rise = arm_q[2] &  sda_s & ~sda_prev_q;
  assign sda_fall = arm_q[2] & ~sda_s &  sda_prev_q;
  assign start_c  = sda_fall & scl_s;
  assign stop_c   = sda_rise & scl_s;
  assign mem_rd   = mem_q[ptr_q];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_h_d  = addr_h_q;
    ptr_d     = ptr_q;
    oe_d      = oe_q;
    ack_d     = ack_q;
    busy_d    = busy_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (start_c) begin
      state_d = S_DEV;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
      ack_d   = 1'b0;
    end else if (stop_c) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
      ack_d   = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_DEV, S_ADDR_H, S_ADDR_L, S_WR: begin
          if (scl_rise && cnt_q != 4'd8) begin
            rx_d  = {rx_q[6:0], sda_s};
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            if (!ack_q) begin
              // start of the ACK slot: byte is complete, act on it now
              ack_d = 1'b1;
              oe_d  = 1'b1;
              case (state_q)
                S_DEV: begin
                  if (rx_q[7:1] == DEV_ADDR) busy_d = 1'b1;
                  else begin
                    ack_d   = 1'b0;
                    oe_d    = 1'b0;
                    state_d = S_SKIP;
                  end
                end
                S_ADDR_H: addr_h_d = rx_q;
                S_ADDR_L: ptr_d = MEM_AW'({(HIGH_ADDR != 0) ? addr_h_q : 8'h00, rx_q});
                default: begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = ptr_q;
                  wr_data_d = rx_q;
                  ptr_d     = ptr_q + 1'b1;
                end
              endcase
            end else begin
              ack_d = 1'b0;
              oe_d  = 1'b0;
              cnt_d = 4'd0;
              case (state_q)
                S_DEV: begin
                  if (rx_q[0]) begin
                    state_d = S_RD;
                    tx_d    = mem_rd[6:0];
                    ptr_d   = ptr_q + 1'b1;
                    oe_d    = ~mem_rd[7];
                  end else begin
                    state_d = (HIGH_ADDR != 0) ? S_ADDR_H : S_ADDR_L;
                  end
                end
                S_ADDR_H: state_d = S_ADDR_L;
                default:  state_d = S_WR;
              endcase
            end
          end
        end
        S_RD: begin
          if (scl_rise && cnt_q != 4'd8) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd0) begin
              tx_d  = mem_rd[6:0];
              ptr_d = ptr_q + 1'b1;
              oe_d  = ~mem_rd[7];
            end else if (cnt_q == 4'd8) begin
              oe_d    = 1'b0;
              cnt_d   = 4'd0;
              state_d = S_RD_ACK;
            end else begin
              tx_d = {tx_q[5:0], 1'b0};
              oe_d = ~tx_q[6];
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            if (!sda_s) state_d = S_RD;
            else begin
              state_d = S_SKIP;
              busy_d  = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      rx_q      <= 8'h00;
      tx_q      <= 7'h00;
      addr_h_q  <= 8'h00;
      ptr_q     <= '0;
      oe_q      <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      addr_h_q  <= addr_h_d;
      ptr_q     <= ptr_d;
      oe_q      <= oe_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en_d) mem_q[wr_addr_d] <= wr_data_d;
  end

  assign sda     = oe_q ? 1'b0 : 1'bz;
  assign busy    = busy_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_i2c_slave_mem.sv
// Bit-banged I2C master driving two slaves (1-byte and 2-byte addressing)
// through directed write/read/wrap/reset sequences.
module tb_i2c_slave_mem;

  localparam int QT = 500;

  logic       clk, rstn, scl, m_oe, sel;
  wire        sda0, sda1;
  logic       busy0, wr_en0, busy1, wr_en1;
  logic [7:0] wr_addr0, wr_data0, wr_addr1, wr_data1;
  logic       sda_obs;

  pullup (sda0);
  pullup (sda1);
  assign sda0    = (m_oe && !sel) ? 1'b0 : 1'bz;
  assign sda1    = (m_oe &&  sel) ? 1'b0 : 1'bz;
  assign sda_obs = sel ? sda1 : sda0;

  i2c_slave_mem #(.DEV_ADDR(7'h51), .HIGH_ADDR(0), .MEM_AW(8)) u_dut0 (
    .clk(clk), .rstn(rstn), .scl(scl), .sda(sda0),
    .busy(busy0), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0));

  i2c_slave_mem #(.DEV_ADDR(7'h51), .HIGH_ADDR(1), .MEM_AW(8)) u_dut1 (
    .clk(clk), .rstn(rstn), .scl(scl), .sda(sda1),
    .busy(busy1), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  logic [15:0] wq0[$];
  logic [15:0] wq1[$];
  always @(negedge clk) begin
    if (wr_en0) wq0.push_back({wr_addr0, wr_data0});
    if (wr_en1) wq1.push_back({wr_addr1, wr_data1});
  end

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic bit_io(input logic d, output logic s);
    m_oe = ~d; #QT;
    scl = 1'b1; #QT;
    s = sda_obs; #QT;
    scl = 1'b0; #QT;
  endtask

  task automatic i2c_start();
    m_oe = 1'b0; #QT;
    scl = 1'b1;  #QT;
    m_oe = 1'b1; #QT;
    scl = 1'b0;  #QT;
  endtask

  task automatic i2c_stop();
    m_oe = 1'b1; #QT;
    scl = 1'b1;  #QT;
    m_oe = 1'b0; #QT;
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_io(b[i], s);
    bit_io(1'b1, s);
    ack = ~s;
  endtask

  task automatic rd_byte(output logic [7:0] b, input logic mack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_io(1'b1, b[i]);
    bit_io(~mack, s);
  endtask

  logic       ack, s;
  logic [7:0] rb;
  logic [4:0] tail;
  int         n0, n1;

  initial begin
    rstn = 1'b0; scl = 1'b1; m_oe = 1'b0; sel = 1'b0;
    #105;
    chk("rst_busy",  busy0, 0);
    chk("rst_wren",  wr_en0, 0);
    chk("rst_waddr", wr_addr0, 0);
    chk("rst_wdata", wr_data0, 0);
    chk("rst_sda",   sda_obs, 1);
    rstn = 1'b1;
    #200;

    // single write 0xFF to 0xBB
    n0 = wq0.size();
    i2c_start();
    wr_byte(8'hA2, ack); chk("w1_ack_dev", ack, 1);
    chk("w1_busy", busy0, 1);
    wr_byte(8'hBB, ack); chk("w1_ack_addr", ack, 1);
    wr_byte(8'hFF, ack); chk("w1_ack_data", ack, 1);
    i2c_stop();
    #200;
    chk("w1_busy_stop", busy0, 0);
    chk("w1_nwr", wq0.size() - n0, 1);
    chk("w1_wr", wq0[n0], 16'hBBFF);

    // write 0xCC to 0xBB, then random read
    n0 = wq0.size();
    i2c_start();
    wr_byte(8'hA2, ack); wr_byte(8'hBB, ack); wr_byte(8'hCC, ack);
    i2c_stop();
    chk("w2_wr", wq0[n0], 16'hBBCC);
    i2c_start();
    wr_byte(8'hA2, ack); wr_byte(8'hBB, ack);
    i2c_start();
    wr_byte(8'hA3, ack); chk("rr_ack_dev", ack, 1);
    rd_byte(rb, 1'b0);   chk("rr_data", rb, 8'hCC);
    m_oe = 1'b0; #100;
    chk("rr_sda_rel", sda_obs, 1);
    chk("rr_busy_nack", busy0, 0);
    i2c_stop();

    // wrong device address
    n0 = wq0.size();
    i2c_start();
    wr_byte(8'hA0, ack); chk("wa_ack_dev", ack, 0);
    chk("wa_busy", busy0, 0);
    wr_byte(8'h55, ack); chk("wa_ack_d0", ack, 0);
    wr_byte(8'h66, ack); chk("wa_ack_d1", ack, 0);
    i2c_stop();
    chk("wa_nwr", wq0.size() - n0, 0);

    // pointer wrap
    n0 = wq0.size();
    i2c_start();
    wr_byte(8'hA2, ack); wr_byte(8'hFF, ack);
    wr_byte(8'h11, ack); wr_byte(8'h22, ack);
    i2c_stop();
    chk("wr_nwr", wq0.size() - n0, 2);
    chk("wr_wr0", wq0[n0], 16'hFF11);
    chk("wr_wr1", wq0[n0+1], 16'h0022);
    i2c_start();
    wr_byte(8'hA2, ack); wr_byte(8'hFF, ack);
    i2c_start();
    wr_byte(8'hA3, ack);
    rd_byte(rb, 1'b1); chk("wr_rd0", rb, 8'h11);
    rd_byte(rb, 1'b0); chk("wr_rd1", rb, 8'h22);
    i2c_stop();

    // two-byte addressing slave
    sel = 1'b1;
    n1 = wq1.size();
    i2c_start();
    wr_byte(8'hA2, ack); chk("h_ack0", ack, 1);
    wr_byte(8'h00, ack); chk("h_ack1", ack, 1);
    wr_byte(8'hBB, ack); chk("h_ack2", ack, 1);
    wr_byte(8'h5A, ack); chk("h_ack3", ack, 1);
    i2c_stop();
    chk("h_nwr", wq1.size() - n1, 1);
    chk("h_wr", wq1[n1], 16'hBB5A);
    i2c_start();
    wr_byte(8'hA2, ack); wr_byte(8'h00, ack); wr_byte(8'hBB, ack);
    i2c_start();
    wr_byte(8'hA3, ack);
    rd_byte(rb, 1'b0); chk("h_rd", rb, 8'h5A);
    i2c_stop();
    sel = 1'b0;

    // reset during bit 4 of a read of 0xCC (bit 4 is a driven 0)
    i2c_start();
    wr_byte(8'hA2, ack); wr_byte(8'hBB, ack);
    i2c_start();
    wr_byte(8'hA3, ack);
    for (int i = 0; i < 3; i++) bit_io(1'b1, rb[7-i]);
    chk("rs_hi3", rb[7:5], 3'b110);
    m_oe = 1'b0; #QT;
    scl = 1'b1; #QT;
    chk("rs_pre_drv", sda_obs, 0);
    rstn = 1'b0; #1;
    chk("rs_sda", sda_obs, 1);
    chk("rs_busy", busy0, 0);
    chk("rs_wren", wr_en0, 0);
    #(QT-1);
    scl = 1'b0; #QT;
    rstn = 1'b1;
    for (int i = 4; i >= 0; i--) bit_io(1'b1, tail[i]);
    chk("rs_ignored", tail, 5'h1F);
    chk("rs_busy_after", busy0, 0);
    i2c_stop();
    i2c_start();
    wr_byte(8'hA2, ack); chk("rs_ack_dev", ack, 1);
    wr_byte(8'hBB, ack);
    i2c_start();
    wr_byte(8'hA3, ack);
    rd_byte(rb, 1'b0); chk("rs_rd", rb, 8'hCC);
    i2c_stop();
    s = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
